// File: rtl/io_seq_pkg.sv
// Shared types and pattern constants for the io_seq pad sequencer.
package io_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_ONES  = 2'd2,
    ST_ZERO  = 2'd3
  } seq_state_e;

  // Sliced down to the pad width by users; pad buses wider than this are not supported.
  localparam int unsigned PAT_MAX_W = 64;
  localparam logic [PAT_MAX_W-1:0] ALL_ONES = '1;
  localparam logic [PAT_MAX_W-1:0] ALL_ZERO = '0;

  // A zero final count skips counting and starts straight at the all-ones pattern.
  function automatic seq_state_e first_state(input logic last_is_zero);
    return last_is_zero ? ST_ONES : ST_COUNT;
  endfunction

endpackage

// File: rtl/io_seq_hold_cnt.sv
// Per-step hold counter: reloads on each pattern change, counts down, flags expiry at zero.
module io_seq_hold_cnt #(
  parameter int unsigned HOLD_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [HOLD_W-1:0] i_value,
  output logic              o_expired
);

  logic [HOLD_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - HOLD_W'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/io_seq_tx.sv
// Pad pattern sequencer: counts 1..last, then all-ones, then all-zeros, each held hold+1 cycles.
// Define IO_SEQ_LOOP_EN to restart directly from the zero pattern while start_i is high.
module io_seq_tx #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HOLD_W = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic [HOLD_W-1:0] hold_i,
  input  logic [WIDTH-1:0]  last_i,
  output logic [WIDTH-1:0]  io_out,
  output logic [WIDTH-1:0]  io_oeb,
  output logic              busy_o,
  output logic              done_o
);

  import io_seq_pkg::*;

  localparam logic [WIDTH-1:0] PAT_ONES = ALL_ONES[WIDTH-1:0];
  localparam logic [WIDTH-1:0] PAT_ZERO = ALL_ZERO[WIDTH-1:0];
  localparam logic [WIDTH-1:0] PAT_ONE  = WIDTH'(1);

  seq_state_e        r_state;
  logic [WIDTH-1:0]  r_pat;
  logic [WIDTH-1:0]  r_oeb;
  logic              r_busy;
  logic              r_done;
  logic [HOLD_W-1:0] r_hold;
  logic [WIDTH-1:0]  r_last;

  seq_state_e        w_nxt_state;
  logic [WIDTH-1:0]  w_nxt_pat;
  logic              w_load;
  logic              w_latch;
  logic              w_done;
  logic [HOLD_W-1:0] w_cnt_val;
  logic              w_expired;

  io_seq_hold_cnt #(
    .HOLD_W (HOLD_W)
  ) u_hold_cnt (
    .i_clk     (wb_clk_i),
    .i_rst     (wb_rst_i),
    .i_load    (w_load),
    .i_value   (w_cnt_val),
    .o_expired (w_expired)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_pat   <= PAT_ZERO;
      r_oeb   <= PAT_ONES;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hold  <= '0;
      r_last  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_pat   <= w_nxt_pat;
      r_oeb   <= (w_nxt_state == ST_IDLE) ? PAT_ONES : PAT_ZERO;
      r_busy  <= (w_nxt_state != ST_IDLE);
      r_done  <= w_done;
      if (w_latch) begin
        r_hold <= hold_i;
        r_last <= last_i;
      end
    end
  end

  // Launch uses hold_i directly since r_hold is only captured on the same edge.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pat   = r_pat;
    w_load      = 1'b0;
    w_latch     = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_latch     = 1'b1;
          w_load      = 1'b1;
          w_nxt_state = first_state(last_i == '0);
          w_nxt_pat   = (last_i == '0) ? PAT_ONES : PAT_ONE;
        end
      end
      ST_COUNT: begin
        if (w_expired) begin
          w_load = 1'b1;
          if (r_pat == r_last) begin
            w_nxt_state = ST_ONES;
            w_nxt_pat   = PAT_ONES;
          end else begin
            w_nxt_pat = r_pat + PAT_ONE;
          end
        end
      end
      ST_ONES: begin
        if (w_expired) begin
          w_load      = 1'b1;
          w_nxt_state = ST_ZERO;
          w_nxt_pat   = PAT_ZERO;
        end
      end
      ST_ZERO: begin
        if (w_expired) begin
          w_done      = 1'b1;
          w_nxt_state = ST_IDLE;
          w_nxt_pat   = PAT_ZERO;
`ifdef IO_SEQ_LOOP_EN
          if (start_i) begin
            w_latch     = 1'b1;
            w_load      = 1'b1;
            w_nxt_state = first_state(last_i == '0);
            w_nxt_pat   = (last_i == '0) ? PAT_ONES : PAT_ONE;
          end
`endif
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_pat   = PAT_ZERO;
      end
    endcase
    w_cnt_val = w_latch ? hold_i : r_hold;
  end

  assign io_out = r_pat;
  assign io_oeb = r_oeb;
  assign busy_o = r_busy;
  assign done_o = r_done;

endmodule

// File: tb/tb_io_seq_tx.sv
// Directed self-checking bench for io_seq_tx; loop-mode case built when IO_SEQ_LOOP_EN is defined.
module tb_io_seq_tx;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned HOLD_W = 16;

  logic              clk   = 1'b0;
  logic              rst   = 1'b0;
  logic              start = 1'b0;
  logic [HOLD_W-1:0] hold  = '0;
  logic [WIDTH-1:0]  last  = '0;
  logic [WIDTH-1:0]  io_out;
  logic [WIDTH-1:0]  io_oeb;
  logic              busy;
  logic              done;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  io_seq_tx #(
    .WIDTH  (WIDTH),
    .HOLD_W (HOLD_W)
  ) u_dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .start_i  (start),
    .hold_i   (hold),
    .last_i   (last),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .busy_o   (busy),
    .done_o   (done)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cycle(input string tag, input logic [7:0] pat, input logic exp_busy,
                           input logic exp_done);
    chk({tag, ".out"},  32'(io_out), 32'(pat));
    chk({tag, ".oeb"},  32'(io_oeb), exp_busy ? 32'h00 : 32'hFF);
    chk({tag, ".busy"}, 32'(busy),   32'(exp_busy));
    chk({tag, ".done"}, 32'(done),   32'(exp_done));
  endtask

  // Called one cycle after launch; checks every held value, then the done/IDLE cycle.
  task automatic run_expect(input string tag, input logic [7:0] vals[$], input int unsigned h);
    foreach (vals[i]) begin
      for (int unsigned k = 0; k <= h; k++) begin
        chk_cycle(tag, vals[i], 1'b1, 1'b0);
        step();
      end
    end
    chk_cycle({tag, ".end"}, 8'h00, 1'b0, 1'b1);
    step();
    chk_cycle({tag, ".post"}, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic launch(input logic [HOLD_W-1:0] h, input logic [WIDTH-1:0] l);
    hold  = h;
    last  = l;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  logic [7:0] q[$];

  initial begin
    #1 rst = 1'b1;
    #2 chk_cycle("reset", 8'h00, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk_cycle("idle", 8'h00, 1'b0, 1'b0);

    // Hold 0, last 10: twelve single-cycle values.
    launch(16'd0, 8'd10);
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00};
    run_expect("h0l10", q, 0);

    // Hold 3, last 2: each value held four cycles, sixteen busy cycles.
    launch(16'd3, 8'd2);
    q = '{8'h01, 8'h02, 8'hFF, 8'h00};
    run_expect("h3l2", q, 3);

    // Last 0: no counting at all.
    launch(16'd1, 8'd0);
    q = '{8'hFF, 8'h00};
    run_expect("l0", q, 1);

    // Last all-ones: FF counted, then held again in ONES.
    launch(16'd0, 8'hFF);
    for (int unsigned i = 0; i < 254; i++) step();
    chk_cycle("lff.cnt", 8'hFF, 1'b1, 1'b0);
    step();
    q = '{8'hFF, 8'h00};
    run_expect("lff", q, 0);

    // Re-pulsed start and mid-run hold/last changes are ignored.
    launch(16'd1, 8'd3);
    q = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'hFF, 8'hFF, 8'h00, 8'h00};
    foreach (q[i]) begin
      chk_cycle("busy_ign", q[i], 1'b1, 1'b0);
      start = (i == 2 || i == 5);
      if (i == 3) begin
        hold = 16'd5;
        last = 8'd7;
      end
      step();
    end
    start = 1'b0;
    chk_cycle("busy_ign.end", 8'h00, 1'b0, 1'b1);
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      chk_cycle("busy_ign.no2nd", 8'h00, 1'b0, 1'b0);
    end

    // Asynchronous reset mid-sequence while io_out is 05.
    launch(16'd0, 8'd10);
    for (int unsigned i = 0; i < 4; i++) step();
    chk("rst_mid.pre", 32'(io_out), 32'h05);
    #2 rst = 1'b1;
    #1 chk_cycle("rst_mid.now", 8'h00, 1'b0, 1'b0);
    step();
    chk_cycle("rst_mid.held", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    launch(16'd0, 8'd1);
    q = '{8'h01, 8'hFF, 8'h00};
    run_expect("rst_rel", q, 0);

`ifdef IO_SEQ_LOOP_EN
    // Start held high: passes chain without visiting IDLE.
    hold  = 16'd0;
    last  = 8'd2;
    start = 1'b1;
    step();
    q = '{8'h01, 8'h02, 8'hFF, 8'h00, 8'h01, 8'h02, 8'hFF, 8'h00};
    foreach (q[i]) begin
      chk_cycle("loop", q[i], 1'b1, (i == 4));
      if (i == 7) start = 1'b0;
      step();
    end
    chk_cycle("loop.end", 8'h00, 1'b0, 1'b1);
`else
    // Start held high through the end of ZERO still returns to IDLE.
    hold  = 16'd0;
    last  = 8'd1;
    start = 1'b1;
    step();
    q = '{8'h01, 8'hFF, 8'h00};
    foreach (q[i]) begin
      chk_cycle("noloop", q[i], 1'b1, 1'b0);
      step();
    end
    chk_cycle("noloop.end", 8'h00, 1'b0, 1'b1);
    start = 1'b0;
    step();
    chk_cycle("noloop.post", 8'h00, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
